// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU result port, load result port and the
// register-file write port. The rs1/rs2 forwarding taps exist only when
// WB_FORWARD_EN is defined.
// slave  = arbiter side, master = producer / register-file side.
interface writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BITS   = 5
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [SEL_BITS-1:0]   alu_sel;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  load_valid;
    logic                  load_ready;
    logic [SEL_BITS-1:0]   load_sel;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  wEn;
    logic [SEL_BITS-1:0]   write_sel;
    logic [DATA_WIDTH-1:0] write_data;

`ifdef WB_FORWARD_EN
    logic [SEL_BITS-1:0]   rs1_sel;
    logic [SEL_BITS-1:0]   rs2_sel;
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;
    logic [DATA_WIDTH-1:0] rs1_fwd_data;
    logic [DATA_WIDTH-1:0] rs2_fwd_data;

    modport slave (
        input  alu_valid, alu_sel, alu_data,
        input  load_valid, load_sel, load_data,
        input  rs1_sel, rs2_sel,
        output alu_ready, load_ready,
        output wEn, write_sel, write_data,
        output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
    );

    modport master (
        output alu_valid, alu_sel, alu_data,
        output load_valid, load_sel, load_data,
        output rs1_sel, rs2_sel,
        input  alu_ready, load_ready,
        input  wEn, write_sel, write_data,
        input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
    );
`else
    modport slave (
        input  alu_valid, alu_sel, alu_data,
        input  load_valid, load_sel, load_data,
        output alu_ready, load_ready,
        output wEn, write_sel, write_data
    );

    modport master (
        output alu_valid, alu_sel, alu_data,
        output load_valid, load_sel, load_data,
        input  alu_ready, load_ready,
        input  wEn, write_sel, write_data
    );
`endif
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the ALU result stream and a buffered load
// result stream onto a single register-file write port.
// ALU results win by default; loads wait in a small FIFO. After
// STARVE_LIMIT consecutive ALU wins with loads pending, one DRAIN cycle
// stalls the ALU and forces the FIFO head out.
// Writes to x0 are accepted and dropped on both paths.
// Optional feature macro: WB_FORWARD_EN adds rs1/rs2 forwarding taps
// off the registered write port.
module writeback_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int SEL_BITS        = 5,
    parameter int LOAD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    writeback_arbiter_if.slave   bus
);
    localparam int PTR_W = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [SEL_BITS-1:0]   sel;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

    // load buffer
    entry_t           mem [LOAD_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // arbitration state
    state_t           state;
    logic             alu_ready_q;
    logic [STV_W-1:0] starve;

    // registered write port
    logic             wen_q;
    entry_t           wr_q;

    logic   fifo_empty;
    logic   fifo_full;
    logic   alu_win;
    logic   pop;
    logic   push;
    logic   grant;
    logic   starve_hit;
    entry_t grant_entry;
    entry_t push_entry;

    // Arbitration decision, all from start-of-cycle state. DRAIN blocks
    // the ALU, so a non-empty FIFO always pops there.
    always_comb begin
        fifo_empty  = (count == '0);
        fifo_full   = (count == CNT_W'(LOAD_FIFO_DEPTH));
        alu_win     = (state == NORMAL) && bus.alu_valid && (bus.alu_sel != '0);
        pop         = !fifo_empty && !alu_win;
        push        = bus.load_valid && !fifo_full && (bus.load_sel != '0);
        grant       = alu_win || pop;
        starve_hit  = alu_win && !fifo_empty && (starve == STV_W'(STARVE_LIMIT - 1));
        push_entry  = '{sel: bus.load_sel, data: bus.load_data};
        grant_entry = alu_win ? entry_t'{sel: bus.alu_sel, data: bus.alu_data}
                              : mem[rd_ptr];
    end

    // NORMAL/DRAIN FSM with the starvation counter; alu_ready is a flop
    // that tracks the state so the ALU sees a clean registered stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= NORMAL;
            alu_ready_q <= 1'b1;
            starve      <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (fifo_empty || pop) begin
                        starve <= '0;
                    end else if (alu_win) begin
                        if (starve_hit) begin
                            state       <= DRAIN;
                            alu_ready_q <= 1'b0;
                            starve      <= '0;
                        end else begin
                            starve <= starve + STV_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    state       <= NORMAL;
                    alu_ready_q <= 1'b1;
                    starve      <= '0;
                end
                default: begin
                    state       <= NORMAL;
                    alu_ready_q <= 1'b1;
                    starve      <= '0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Registered write port: one-cycle wEn pulse per grant, sel/data hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q <= 1'b0;
            wr_q  <= '0;
        end else begin
            wen_q <= grant;
            if (grant) wr_q <= grant_entry;
        end
    end

    assign bus.alu_ready  = alu_ready_q;
    assign bus.load_ready = !fifo_full;
    assign bus.wEn        = wen_q;
    assign bus.write_sel  = wr_q.sel;
    assign bus.write_data = wr_q.data;

`ifdef WB_FORWARD_EN
    // Forward the write in flight to matching read ports; x0 never forwards.
    always_comb begin
        bus.rs1_fwd_valid = 1'b0;
        bus.rs1_fwd_data  = '0;
        bus.rs2_fwd_valid = 1'b0;
        bus.rs2_fwd_data  = '0;
        if (wen_q && (bus.rs1_sel != '0) && (wr_q.sel == bus.rs1_sel)) begin
            bus.rs1_fwd_valid = 1'b1;
            bus.rs1_fwd_data  = wr_q.data;
        end
        if (wen_q && (bus.rs2_sel != '0) && (wr_q.sel == bus.rs2_sel)) begin
            bus.rs2_fwd_valid = 1'b1;
            bus.rs2_fwd_data  = wr_q.data;
        end
    end
`endif

endmodule
